register_file: RTL
==================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL provide parameter: WIDTH, 32, data bits per entry; multiple of 8.
REQ-002 SHALL provide parameter: ADDR_W, 5, address bits; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL provide parameter: ZERO_REG, 1, when 1 entry 0 is hardwired to zero.
REQ-004 SHALL provide port: clock  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL provide port: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL provide port: clear  input  1  synchronous clear of all entries.
REQ-007 SHALL provide port: write  input  1  write enable.
REQ-008 SHALL provide port: write_addr  input  ADDR_W  write entry index.
REQ-009 SHALL provide port: write_data  input  WIDTH  write data.
REQ-010 SHALL provide port: byte_en  input  WIDTH/8  per-byte write mask; bit i covers bits 8i+7:8i.
REQ-011 SHALL provide port: read_addr_a  input  ADDR_W  read port A index.
REQ-012 SHALL provide port: read_addr_b  input  ADDR_W  read port B index.
REQ-013 SHALL provide port: read_data_a  output  WIDTH  registered read data, port A.
REQ-014 SHALL provide port: read_data_b  output  WIDTH  registered read data, port B.

Function
REQ-015 SHALL, on a rising edge with write=1 and clear=0, update only the byte lanes of entry write_addr whose byte_en bit is 1; other lanes hold.
REQ-016 SHALL ignore writes with byte_en all-zero; the entry holds.
REQ-017 SHALL, when ZERO_REG=1, discard writes to entry 0 and always return 0 for reads of entry 0.
REQ-018 SHALL register both read ports: read_data_x after edge N reflects read_addr_x sampled at edge N (1-cycle latency, no read enable).
REQ-019 SHALL serve ports A and B independently; equal addresses on A and B return identical data.
REQ-020 SHALL, on a rising edge with clear=1, set every entry to 0 and both read_data outputs to 0; clear has priority over write in that cycle.
REQ-021 SHALL hold every entry whose address is not written and not cleared.
REQ-022 SHALL treat read/write address collision per REQ-030/REQ-031.
REQ-023 SHALL keep all state in flip-flops; no latches and no combinational path from any input to read_data_x.

Reset
REQ-024 SHALL, while reset=0, force every entry and both read_data outputs to 0 immediately, independent of clock.
REQ-025 SHALL ignore write and clear while reset=0.
REQ-026 SHALL, on reset assertion mid-write, leave the target entry 0 (no partial update).
REQ-027 SHALL resume normal operation on the first rising edge after reset returns to 1.

Configuration
REQ-028 SHALL gate write-to-read forwarding with macro REGISTER_FILE_BYPASS_EN.
REQ-029 SHALL behave identically with and without the macro except on address collision.
REQ-030 SHALL, with REGISTER_FILE_BYPASS_EN defined and a same-edge write and read of one address, load read_data_x with the byte-merged new value (enabled lanes from write_data, others from stored value); never for entry 0 when ZERO_REG=1.
REQ-031 SHALL, without the macro, load read_data_x with the pre-write stored value on collision; new value visible one edge later.

Verification
REQ-032 SHALL cover: reset=0 after filling entries with 32'hFFFF_FFFF -> all entries and both read_data = 0 without a clock edge.
REQ-033 SHALL cover: write entry 3 = 32'hDEAD_BEEF, byte_en=4'b1111, then read A=3 -> read_data_a = 32'hDEAD_BEEF one edge after the read address is applied.
REQ-034 SHALL cover: entry 5 = 32'h1122_3344, write 32'hAABB_CCDD with byte_en=4'b0101 -> entry 5 reads 32'h11BB_33DD.
REQ-035 SHALL cover: ZERO_REG=1, write entry 0 = 32'h1234_5678 -> read_data_a and read_data_b of entry 0 = 0.
REQ-036 SHALL cover: entry 7 = 32'h0, same-edge write 32'hCAFE_F00D and read A=7 -> read_data_a = 32'hCAFE_F00D with macro, 32'h0 without.
REQ-037 SHALL cover: clear=1 and write=1 to entry 2 on one edge -> entry 2 and both read_data = 0.

Source files
------------

// File: rtl/register_file.sv
// Multi-port register file: one byte-masked write port, two registered read ports.
// Define REGISTER_FILE_BYPASS_EN to forward same-edge write data onto colliding reads.
module register_file #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 write,
  input  logic [ADDR_W-1:0]    write_addr,
  input  logic [WIDTH-1:0]     write_data,
  input  logic [WIDTH/8-1:0]   byte_en,
  input  logic [ADDR_W-1:0]    read_addr_a,
  input  logic [ADDR_W-1:0]    read_addr_b,
  output logic [WIDTH-1:0]     read_data_a,
  output logic [WIDTH-1:0]     read_data_b
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = WIDTH / 8;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_a_q, rd_a_d;
  logic [WIDTH-1:0] rd_b_q, rd_b_d;

  logic             wr_en_c;
  logic [WIDTH-1:0] wr_merge_c;

  // Entry 0 is read-only when hardwired; an all-zero mask changes nothing.
  always_comb begin
    wr_en_c = write && (|byte_en) &&
              !((ZERO_REG != 0) && (write_addr == '0));
  end

  // Byte-merge the incoming data over the currently stored word.
  always_comb begin
    wr_merge_c = mem_q[write_addr];
    for (int unsigned l = 0; l < NB; l++) begin
      if (byte_en[l]) begin
        wr_merge_c[8*l +: 8] = write_data[8*l +: 8];
      end
    end
  end

  // Next-state of the storage array: clear wins over write.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
    end else if (wr_en_c) begin
      mem_d[write_addr] = wr_merge_c;
    end
  end

  // Read port A next value.
  always_comb begin
    rd_a_d = mem_q[read_addr_a];
`ifdef REGISTER_FILE_BYPASS_EN
    if (wr_en_c && (read_addr_a == write_addr)) begin
      rd_a_d = wr_merge_c;
    end
`endif
    if ((ZERO_REG != 0) && (read_addr_a == '0)) begin
      rd_a_d = '0;
    end
    if (clear) begin
      rd_a_d = '0;
    end
  end

  // Read port B next value.
  always_comb begin
    rd_b_d = mem_q[read_addr_b];
`ifdef REGISTER_FILE_BYPASS_EN
    if (wr_en_c && (read_addr_b == write_addr)) begin
      rd_b_d = wr_merge_c;
    end
`endif
    if ((ZERO_REG != 0) && (read_addr_b == '0)) begin
      rd_b_d = '0;
    end
    if (clear) begin
      rd_b_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign read_data_a = rd_a_q;
  assign read_data_b = rd_b_q;

endmodule
